// File: rtl/sd_spi_pkg.sv
// Shared types and constants for the SD-card SPI-mode responder.
// R1 status bits, command indices, the data token and the FSM state encoding.
package sd_spi_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ARGS,
        ST_NCR,
        ST_RESP,
        ST_GAP,
        ST_TOKEN,
        ST_DATA,
        ST_CRC
    } state_t;

    localparam logic [5:0] CMD_GO_IDLE    = 6'd0;
    localparam logic [5:0] CMD_SEND_IF    = 6'd8;
    localparam logic [5:0] CMD_READ_BLOCK = 6'd17;
    localparam logic [5:0] CMD_SEND_OP    = 6'd41;
    localparam logic [5:0] CMD_APP        = 6'd55;
    localparam logic [5:0] CMD_READ_OCR   = 6'd58;

    localparam logic [7:0] R1_IDLE        = 8'h01;
    localparam logic [7:0] R1_ILLEGAL     = 8'h04;
    localparam logic [7:0] DATA_TOKEN     = 8'hFE;
    localparam logic [7:0] FILL_BYTE      = 8'hFF;

    localparam logic [8:0] LAST_BYTE_IDX  = 9'd511;

    function automatic logic [7:0] r1_status(input logic idle, input logic illegal);
        return (idle ? R1_IDLE : 8'h00) | (illegal ? R1_ILLEGAL : 8'h00);
    endfunction

endpackage

// File: rtl/sd_spi_shifter.sv
// SPI mode-0 bit engine: input synchronizers, SCLK edge detection,
// receive shifter with byte strobe and transmit shifter driving MISO.
module sd_spi_shifter #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic       SD_CS,
    input  logic       SCLK,
    input  logic       MOSI,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       miso,
    output logic       cs_high,
    output logic       rx_done,
    output logic [7:0] rx_byte
);

    // bit 2 = SD_CS, bit 1 = SCLK, bit 0 = MOSI
    logic [SYNC_STAGES-1:0][2:0] sync_reg;
    logic [2:0] sync_out;
    logic       cs_s;
    logic       sclk_s;
    logic       mosi_s;

    logic       sclk_prev_reg;
    logic       cs_prev_reg;
    logic [2:0] bit_cnt_reg;
    logic [6:0] rx_shift_reg;
    logic [6:0] tx_shift_reg;
    logic       miso_reg;

    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs_fall;

    assign sync_out  = sync_reg[SYNC_STAGES-1];
    assign cs_s      = sync_out[2];
    assign sclk_s    = sync_out[1];
    assign mosi_s    = sync_out[0];

    assign sclk_rise = sclk_s & ~sclk_prev_reg;
    assign sclk_fall = ~sclk_s & sclk_prev_reg;
    assign cs_fall   = ~cs_s & cs_prev_reg;

    assign rx_done   = sclk_rise & ~cs_s & ~cs_fall & (bit_cnt_reg == 3'd7);
    assign rx_byte   = {rx_shift_reg, mosi_s};
    assign cs_high   = cs_s;
    assign miso      = miso_reg;

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= 3'b101;
            end
        end else begin
            sync_reg[0] <= {SD_CS, SCLK, MOSI};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_reg[i] <= sync_reg[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            sclk_prev_reg <= 1'b0;
            cs_prev_reg   <= 1'b1;
            bit_cnt_reg   <= 3'd0;
            rx_shift_reg  <= 7'd0;
            tx_shift_reg  <= 7'h7F;
            miso_reg      <= 1'b1;
        end else begin
            sclk_prev_reg <= sclk_s;
            cs_prev_reg   <= cs_s;
            if (cs_s) begin
                bit_cnt_reg  <= 3'd0;
                tx_shift_reg <= 7'h7F;
                miso_reg     <= 1'b1;
            end else if (cs_fall) begin
                bit_cnt_reg  <= 3'd0;
            end else begin
                if (sclk_rise) begin
                    rx_shift_reg <= {rx_shift_reg[5:0], mosi_s};
                    bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                end
                // A falling edge with the counter at zero follows a byte boundary:
                // that is where the next queued byte starts driving MISO.
                if (sclk_fall) begin
                    if (bit_cnt_reg == 3'd0) begin
                        miso_reg     <= tx_valid ? tx_byte[7]   : 1'b1;
                        tx_shift_reg <= tx_valid ? tx_byte[6:0] : 7'h7F;
                    end else begin
                        miso_reg     <= tx_shift_reg[6];
                        tx_shift_reg <= {tx_shift_reg[5:0], 1'b1};
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode command responder: parses command frames, answers
// CMD0/8/17/41/55/58 and streams a 512-byte block fetched through BYTE_REQ.
module sd_spi_responder
    import sd_spi_pkg::*;
#(
    parameter int          SYNC_STAGES  = 2,
    parameter logic [31:0] OCR          = 32'h40FF8000,
    parameter int          ACMD41_TRIES = 2
) (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        SD_CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic [31:0] BLK_ADDR,
    output logic [8:0]  BYTE_IDX,
    output logic        BYTE_REQ,
    input  logic [7:0]  BYTE_DATA,
    output logic        CARD_IDLE
);

    logic       cs_high;
    logic       rx_done;
    logic [7:0] rx_byte;

    state_t      state_reg,    state_next;
    logic [5:0]  cmd_reg,      cmd_next;
    logic [31:0] arg_reg,      arg_next;
    logic [2:0]  arg_cnt_reg,  arg_cnt_next;
    logic [31:0] resp_reg,     resp_next;
    logic [2:0]  resp_cnt_reg, resp_cnt_next;
    logic        go_data_reg,  go_data_next;
    logic [7:0]  tx_byte_reg,  tx_byte_next;
    logic        tx_valid_reg, tx_valid_next;
    logic [8:0]  idx_reg,      idx_next;
    logic        byte_req_reg, byte_req_next;
    logic [1:0]  req_pipe_reg, req_pipe_next;
    logic [31:0] blk_addr_reg, blk_addr_next;
    logic        idle_reg,     idle_next;
    logic [7:0]  acmd_cnt_reg, acmd_cnt_next;
    logic        cmd55_reg,    cmd55_next;
    logic        crc_cnt_reg,  crc_cnt_next;
    logic [7:0]  acmd_inc;
    logic [7:0]  r1;

    sd_spi_shifter #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_shifter (
        .clk      (clk),
        .RESET_N  (RESET_N),
        .SD_CS    (SD_CS),
        .SCLK     (SCLK),
        .MOSI     (MOSI),
        .tx_byte  (tx_byte_reg),
        .tx_valid (tx_valid_reg),
        .miso     (MISO),
        .cs_high  (cs_high),
        .rx_done  (rx_done),
        .rx_byte  (rx_byte)
    );

    assign BLK_ADDR  = blk_addr_reg;
    assign BYTE_IDX  = idx_reg;
    assign BYTE_REQ  = byte_req_reg;
    assign CARD_IDLE = idle_reg;

    always_ff @(posedge clk) begin
        if (!RESET_N) begin
            state_reg    <= ST_HUNT;
            cmd_reg      <= 6'd0;
            arg_reg      <= 32'd0;
            arg_cnt_reg  <= 3'd0;
            resp_reg     <= 32'd0;
            resp_cnt_reg <= 3'd0;
            go_data_reg  <= 1'b0;
            tx_byte_reg  <= FILL_BYTE;
            tx_valid_reg <= 1'b0;
            idx_reg      <= 9'd0;
            byte_req_reg <= 1'b0;
            req_pipe_reg <= 2'b00;
            blk_addr_reg <= 32'd0;
            idle_reg     <= 1'b1;
            acmd_cnt_reg <= 8'd0;
            cmd55_reg    <= 1'b0;
            crc_cnt_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_reg      <= cmd_next;
            arg_reg      <= arg_next;
            arg_cnt_reg  <= arg_cnt_next;
            resp_reg     <= resp_next;
            resp_cnt_reg <= resp_cnt_next;
            go_data_reg  <= go_data_next;
            tx_byte_reg  <= tx_byte_next;
            tx_valid_reg <= tx_valid_next;
            idx_reg      <= idx_next;
            byte_req_reg <= byte_req_next;
            req_pipe_reg <= req_pipe_next;
            blk_addr_reg <= blk_addr_next;
            idle_reg     <= idle_next;
            acmd_cnt_reg <= acmd_cnt_next;
            cmd55_reg    <= cmd55_next;
            crc_cnt_reg  <= crc_cnt_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cmd_next      = cmd_reg;
        arg_next      = arg_reg;
        arg_cnt_next  = arg_cnt_reg;
        resp_next     = resp_reg;
        resp_cnt_next = resp_cnt_reg;
        go_data_next  = go_data_reg;
        tx_byte_next  = tx_byte_reg;
        tx_valid_next = tx_valid_reg;
        idx_next      = idx_reg;
        byte_req_next = 1'b0;
        req_pipe_next = {req_pipe_reg[0], byte_req_reg};
        blk_addr_next = blk_addr_reg;
        idle_next     = idle_reg;
        acmd_cnt_next = acmd_cnt_reg;
        cmd55_next    = cmd55_reg;
        crc_cnt_next  = crc_cnt_reg;
        acmd_inc      = (acmd_cnt_reg == 8'hFF) ? 8'hFF : acmd_cnt_reg + 8'd1;
        r1            = 8'h00;

        // Block data arrives two cycles after the request, well before the next MISO load.
        if (req_pipe_reg[1]) begin
            tx_byte_next = BYTE_DATA;
        end

        if (cs_high) begin
            state_next    = ST_HUNT;
            tx_valid_next = 1'b0;
        end else if (rx_done) begin
            case (state_reg)
                ST_HUNT: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        cmd_next     = rx_byte[5:0];
                        arg_cnt_next = 3'd0;
                        state_next   = ST_ARGS;
                    end
                end
                ST_ARGS: begin
                    if (arg_cnt_reg != 3'd4) begin
                        arg_next     = {arg_reg[23:0], rx_byte};
                        arg_cnt_next = arg_cnt_reg + 3'd1;
                    end else begin
                        state_next    = ST_NCR;
                        tx_byte_next  = FILL_BYTE;
                        tx_valid_next = 1'b1;
                    end
                end
                ST_NCR: begin
                    resp_next     = 32'd0;
                    resp_cnt_next = 3'd0;
                    go_data_next  = 1'b0;
                    cmd55_next    = 1'b0;
                    case (cmd_reg)
                        CMD_GO_IDLE: begin
                            idle_next     = 1'b1;
                            acmd_cnt_next = 8'd0;
                            r1            = R1_IDLE;
                        end
                        CMD_SEND_IF: begin
                            r1            = r1_status(idle_reg, 1'b0);
                            resp_next     = {24'h000001, arg_reg[7:0]};
                            resp_cnt_next = 3'd4;
                        end
                        CMD_APP: begin
                            r1         = r1_status(idle_reg, 1'b0);
                            cmd55_next = 1'b1;
                        end
                        CMD_SEND_OP: begin
                            if (cmd55_reg) begin
                                acmd_cnt_next = acmd_inc;
                                if (acmd_inc >= 8'(ACMD41_TRIES)) begin
                                    idle_next = 1'b0;
                                end
                                r1 = r1_status(idle_next, 1'b0);
                            end else begin
                                r1 = r1_status(idle_reg, 1'b1);
                            end
                        end
                        CMD_READ_OCR: begin
                            r1            = r1_status(idle_reg, 1'b0);
                            resp_next     = OCR;
                            resp_cnt_next = 3'd4;
                        end
                        CMD_READ_BLOCK: begin
                            if (idle_reg) begin
                                r1 = r1_status(1'b1, 1'b1);
                            end else begin
                                r1            = 8'h00;
                                blk_addr_next = arg_reg;
                                go_data_next  = 1'b1;
                            end
                        end
                        default: begin
                            r1 = r1_status(idle_reg, 1'b1);
                        end
                    endcase
                    tx_byte_next = r1;
                    state_next   = ST_RESP;
                end
                ST_RESP: begin
                    if (resp_cnt_reg != 3'd0) begin
                        tx_byte_next  = resp_reg[31:24];
                        resp_next     = {resp_reg[23:0], 8'h00};
                        resp_cnt_next = resp_cnt_reg - 3'd1;
                    end else if (go_data_reg) begin
                        tx_byte_next = FILL_BYTE;
                        state_next   = ST_GAP;
                    end else begin
                        tx_valid_next = 1'b0;
                        state_next    = ST_HUNT;
                    end
                end
                ST_GAP: begin
                    tx_byte_next = DATA_TOKEN;
                    state_next   = ST_TOKEN;
                end
                ST_TOKEN: begin
                    idx_next      = 9'd0;
                    byte_req_next = 1'b1;
                    state_next    = ST_DATA;
                end
                ST_DATA: begin
                    if (idx_reg == LAST_BYTE_IDX) begin
                        tx_byte_next = FILL_BYTE;
                        crc_cnt_next = 1'b0;
                        state_next   = ST_CRC;
                    end else begin
                        idx_next      = idx_reg + 9'd1;
                        byte_req_next = 1'b1;
                    end
                end
                ST_CRC: begin
                    if (!crc_cnt_reg) begin
                        crc_cnt_next = 1'b1;
                    end else begin
                        tx_valid_next = 1'b0;
                        state_next    = ST_HUNT;
                    end
                end
                default: begin
                    state_next = ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_spi_responder.sv
// Drives SPI command frames into sd_spi_responder and checks every MISO byte
// against a command-level model of the card plus a block-memory responder.
module tb_sd_spi_responder;

    localparam int          H            = 4;
    localparam int          SYNC_STAGES  = 2;
    localparam logic [31:0] OCR          = 32'h40FF8000;
    localparam int          ACMD41_TRIES = 2;

    logic        clk = 1'b0;
    logic        RESET_N = 1'b0;
    logic        SD_CS = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b1;
    logic        MISO;
    logic [31:0] BLK_ADDR;
    logic [8:0]  BYTE_IDX;
    logic        BYTE_REQ;
    logic [7:0]  BYTE_DATA = 8'h00;
    logic        CARD_IDLE;

    always #5 clk = ~clk;

    sd_spi_responder #(
        .SYNC_STAGES  (SYNC_STAGES),
        .OCR          (OCR),
        .ACMD41_TRIES (ACMD41_TRIES)
    ) dut (
        .clk       (clk),
        .RESET_N   (RESET_N),
        .SD_CS     (SD_CS),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .BLK_ADDR  (BLK_ADDR),
        .BYTE_IDX  (BYTE_IDX),
        .BYTE_REQ  (BYTE_REQ),
        .BYTE_DATA (BYTE_DATA),
        .CARD_IDLE (CARD_IDLE)
    );

    int tests = 0;
    int failed = 0;

    // Block memory: byte n of any block reads as n[7:0], valid only in the cycle two clocks after the request.
    logic       req_d = 1'b0;
    logic [8:0] idx_d = 9'd0;
    int         req_cnt = 0;
    int         req_bad = 0;
    int         req_wide = 0;
    logic [8:0] last_idx = 9'd0;
    logic       req_prev = 1'b0;

    always @(posedge clk) begin
        req_d <= BYTE_REQ;
        idx_d <= BYTE_IDX;
        BYTE_DATA <= req_d ? idx_d[7:0] : 8'($urandom);
        if (BYTE_REQ) begin
            req_cnt++;
            if (BYTE_IDX != 9'd0 && BYTE_IDX != last_idx + 9'd1) req_bad++;
            last_idx = BYTE_IDX;
        end
        if (BYTE_REQ && req_prev) req_wide++;
        req_prev = BYTE_REQ;
    end

    // Card model at the command level
    logic        m_idle = 1'b1;
    int          m_acnt = 0;
    logic        m_c55 = 1'b0;
    logic [31:0] m_blk = 32'd0;
    logic [7:0]  exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_cmd(input logic [5:0] c, input logic [31:0] a, input int ndata);
        logic [7:0] r1;
        exp_q.delete();
        exp_q.push_back(8'hFF);
        if (c == 6'd0) begin
            m_idle = 1'b1;
            m_acnt = 0;
            r1 = 8'h01;
        end else if (c == 6'd41 && m_c55) begin
            m_acnt++;
            if (m_acnt >= ACMD41_TRIES) m_idle = 1'b0;
            r1 = m_idle ? 8'h01 : 8'h00;
        end else if (c == 6'd8 || c == 6'd55 || c == 6'd58) begin
            r1 = m_idle ? 8'h01 : 8'h00;
        end else if (c == 6'd17) begin
            r1 = m_idle ? 8'h05 : 8'h00;
        end else begin
            r1 = m_idle ? 8'h05 : 8'h04;
        end
        exp_q.push_back(r1);
        if (c == 6'd8) begin
            exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            exp_q.push_back(8'h01); exp_q.push_back(a[7:0]);
        end
        if (c == 6'd58) begin
            exp_q.push_back(OCR[31:24]); exp_q.push_back(OCR[23:16]);
            exp_q.push_back(OCR[15:8]);  exp_q.push_back(OCR[7:0]);
        end
        if (c == 6'd17 && !m_idle) begin
            m_blk = a;
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFE);
            for (int n = 0; n < ndata; n++) exp_q.push_back(8'(n));
            if (ndata == 512) begin
                exp_q.push_back(8'hFF);
                exp_q.push_back(8'hFF);
            end
        end
        m_c55 = (c == 6'd55);
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            repeat (H) @(negedge clk);
            rx[i] = MISO;
            SCLK = 1'b1;
            repeat (H) @(negedge clk);
            SCLK = 1'b0;
        end
    endtask

    task automatic fill(input int n);
        logic [7:0] rx;
        for (int i = 0; i < n; i++) begin
            xfer(8'hFF, rx);
            check("hunt_fill", 32'(rx), 32'hFF);
        end
    endtask

    task automatic do_cmd(input logic [5:0] c, input logic [31:0] a, input logic [7:0] crc,
                          input int ndata, input string tag);
        logic [7:0] frame[6];
        logic [7:0] rx;
        model_cmd(c, a, ndata);
        frame[0] = {2'b01, c};
        frame[1] = a[31:24]; frame[2] = a[23:16]; frame[3] = a[15:8]; frame[4] = a[7:0];
        frame[5] = crc;
        for (int i = 0; i < 6; i++) begin
            xfer(frame[i], rx);
            check({tag, "_cmdphase"}, 32'(rx), 32'hFF);
        end
        foreach (exp_q[i]) begin
            xfer(8'hFF, rx);
            check($sformatf("%s_byte%0d", tag, i), 32'(rx), 32'(exp_q[i]));
        end
        check({tag, "_idle"}, 32'(CARD_IDLE), 32'(m_idle));
        check({tag, "_blkaddr"}, BLK_ADDR, m_blk);
    endtask

    task automatic abort_cs();
        for (int i = 0; i < 3; i++) begin
            repeat (H) @(negedge clk);
            SCLK = 1'b1;
            repeat (H) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (2) @(negedge clk);
        SD_CS = 1'b1;
        repeat (SYNC_STAGES + 3) @(negedge clk);
        check("cs_high_miso", 32'(MISO), 32'h1);
        repeat (4) @(negedge clk);
        check("cs_high_miso_hold", 32'(MISO), 32'h1);
        SD_CS = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int         req_base;
        logic [5:0] c;
        logic [31:0] a;
        int         nd;
        logic       go;

        repeat (5) @(negedge clk);
        check("reset_miso",     32'(MISO),      32'h1);
        check("reset_byte_req", 32'(BYTE_REQ),  32'h0);
        check("reset_byte_idx", 32'(BYTE_IDX),  32'h0);
        check("reset_blk_addr", BLK_ADDR,       32'h0);
        check("reset_card_idle",32'(CARD_IDLE), 32'h1);
        RESET_N = 1'b1;
        repeat (4) @(negedge clk);
        SD_CS = 1'b0;
        repeat (4) @(negedge clk);

        fill(2);
        do_cmd(6'd17, 32'h10, 8'hFF, 0, "cmd17_idle");
        do_cmd(6'd5,  32'h0,  8'hFF, 0, "cmd5_idle");
        fill(1);
        do_cmd(6'd0,  32'h0,  8'h95, 0, "cmd0");
        do_cmd(6'd8,  32'h1AA, 8'h87, 0, "cmd8");
        do_cmd(6'd55, 32'h0,  8'h65, 0, "cmd55_a");
        do_cmd(6'd41, 32'h40000000, 8'h77, 0, "acmd41_a");
        do_cmd(6'd55, 32'h0,  8'h65, 0, "cmd55_b");
        do_cmd(6'd41, 32'h40000000, 8'h77, 0, "acmd41_b");
        do_cmd(6'd5,  32'h0,  8'hFF, 0, "cmd5_ready");
        do_cmd(6'd41, 32'h0,  8'hFF, 0, "cmd41_noapp");
        do_cmd(6'd58, 32'h0,  8'hFD, 0, "cmd58");

        req_base = req_cnt;
        do_cmd(6'd17, 32'h10, 8'h3C, 512, "cmd17_full");
        check("byte_req_pulses", 32'(req_cnt - req_base), 32'd512);
        check("byte_req_order",  32'(req_bad),  32'd0);
        check("byte_req_width",  32'(req_wide), 32'd0);
        check("byte_idx_last",   32'(BYTE_IDX), 32'd511);

        do_cmd(6'd17, 32'h0000_2000, 8'h11, 100, "cmd17_abort");
        abort_cs();
        do_cmd(6'd0, 32'h0, 8'h95, 0, "cmd0_after_abort");

        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 5))
                0: c = 6'd55;
                1: c = 6'd41;
                2: c = 6'd8;
                3: c = 6'd58;
                4: c = 6'd17;
                default: c = 6'($urandom_range(0, 63));
            endcase
            a  = $urandom;
            go = (c == 6'd17) && !m_idle;
            nd = go ? int'($urandom_range(1, 8)) : 0;
            fill(int'($urandom_range(0, 2)));
            do_cmd(c, a, 8'($urandom), nd, $sformatf("rand%0d_cmd%0d", t, c));
            if (go) abort_cs();
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: SCLK/SD_CS/MOSI synchronizer depth.
REQ-002 Parameter OCR, default 32'h40FF8000: value returned by CMD58.
REQ-003 Parameter ACMD41_TRIES, default 2: ACMD41 count at which the card leaves idle.
REQ-004 clk  input  1  system clock; all logic on rising edge; clk >= 8x SCLK.
REQ-005 RESET_N  input  1  synchronous, active-low reset.
REQ-006 SD_CS  input  1  SPI chip select, active low.
REQ-007 SCLK  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-008 MOSI  input  1  serial data from host, MSB first.
REQ-009 MISO  output  1  serial data to host, MSB first.
REQ-010 BLK_ADDR  output  32  argument of the last accepted CMD17.
REQ-011 BYTE_IDX  output  9  index of the requested block byte.
REQ-012 BYTE_REQ  output  1  one-clk pulse requesting byte BYTE_IDX of BLK_ADDR.
REQ-013 BYTE_DATA  input  8  requested byte, valid exactly 2 clk after BYTE_REQ.
REQ-014 CARD_IDLE  output  1  high while the card is in idle state (R1 bit 0).

Function
REQ-015 SD_CS, SCLK, MOSI shall pass through SYNC_STAGES flops; SCLK edges detected on synchronized signal.
REQ-016 MOSI sampled on synchronized SCLK rising edge; MISO updated on falling edge; byte boundary after 8 rising edges.
REQ-017 MISO shall be 1 whenever SD_CS high or no byte queued for transmission.
REQ-018 States: HUNT, ARGS, NCR, RESP, GAP, TOKEN, DATA, CRC.
REQ-019 HUNT: received bytes discarded until one with bits[7:6]=01; its bits[5:0] latched as command index -> ARGS.
REQ-020 ARGS: 4 argument bytes (MSB first) then 1 CRC byte received; CRC not checked -> NCR.
REQ-021 NCR: transmit one 0xFF byte -> RESP.
REQ-022 RESP: transmit R1 plus trailing bytes per command, then -> HUNT or GAP (CMD17 accepted).
REQ-023 CMD0: R1=0x01; sets idle, clears ACMD41 counter and CMD55 flag.
REQ-024 CMD8: R1 then 4 bytes 0x00,0x00,0x01, argument[7:0].
REQ-025 CMD55: R1, sets CMD55 flag; any other command clears it after responding.
REQ-026 CMD41 with CMD55 flag: counter increments; R1=0x00 and idle cleared when counter reaches ACMD41_TRIES, else 0x01.
REQ-027 CMD58: R1 then OCR MSB first.
REQ-028 CMD17 when not idle: R1=0x00, BLK_ADDR latched -> GAP; when idle: R1=0x05, no data.
REQ-029 Any other command (incl. CMD41 without CMD55): R1 = idle | 0x04.
REQ-030 GAP: one 0xFF byte; TOKEN: 0xFE; DATA: 512 bytes idx 0..511; CRC: two 0xFF bytes -> HUNT.
REQ-031 BYTE_REQ for idx n issued at the byte boundary preceding transmission of byte n; BYTE_DATA latched 2 clk later, before next falling edge.
REQ-032 Incoming MOSI ignored in NCR..CRC states.
REQ-033 SD_CS rising mid-operation: state -> HUNT, bit counter cleared, MISO=1; idle/ACMD41 state retained.
REQ-034 Bit counter cleared on SD_CS falling edge.

Reset
REQ-035 Reset: state HUNT, MISO=1, BYTE_REQ=0, BYTE_IDX=0, BLK_ADDR=0, CARD_IDLE=1, counters/flags 0.

Structure
REQ-036 Shared package sd_spi_pkg: state enum, command-index constants (CMD0/8/17/41/55/58), R1 bit constants, token 0xFE.
REQ-037 One sub-module sd_spi_shifter: synchronizers, edge detect, rx/tx shift registers, byte-done strobe.

Verification
REQ-038 Reset, CMD0 40 00 00 00 00 95 -> MISO bytes FF then 01; CARD_IDLE=1.
REQ-039 CMD8 48 00 00 01 AA 87 -> FF, 01, 00, 00, 01, AA.
REQ-040 CMD55, CMD41 twice each -> R1 01 then 00; CARD_IDLE falls after second; CMD58 -> 00, 40, FF, 80, 00.
REQ-041 CMD17 arg 0x00000010, BYTE_DATA=idx[7:0] -> FF,00,FF,FE, bytes 00..FF,00..FF, FF,FF; BLK_ADDR=0x10; 512 BYTE_REQ pulses.
REQ-042 CMD17 before init -> 05; CMD5 -> 05 when idle, 04 after init; 0xFF fill bytes ignored in HUNT.
REQ-043 SD_CS raised at data byte 100 -> MISO=1, next CMD0 answered normally.
